// File: rtl/kyber_pkg.sv
// ML-KEM constants, butterfly mode encoding and pipeline latencies for bfu_lanes.
// BFU_LANES_CANON_EN selects the latency of the canonicalising build.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;

  typedef enum logic {
    BFU_CT = 1'b0,
    BFU_GS = 1'b1
  } bfu_mode_e;

  localparam int unsigned BFU_LAT_RAW   = 5;
  localparam int unsigned BFU_LAT_CANON = 6;
`ifdef BFU_LANES_CANON_EN
  localparam int unsigned BFU_LAT = BFU_LAT_CANON;
`else
  localparam int unsigned BFU_LAT = BFU_LAT_RAW;
`endif

endpackage

// File: rtl/bfu_mont_mul.sv
// Single-lane Montgomery multiplier: three stall-able stages (x*t, *QINV, subtract/shift).
module bfu_mont_mul
  import kyber_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int          Q    = KYBER_Q,
  parameter int          QINV = KYBER_QINV
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_t,
  output logic signed [W-1:0] o_r
);

  localparam logic signed [W-1:0]   QinvW = W'(QINV);
  localparam logic signed [2*W-1:0] QW    = (2*W)'(Q);

  logic signed [2*W-1:0] p_d, p_q, p2_q, mq;
  logic        [W-1:0]   m_d;
  logic signed [W-1:0]   m_q, r_d, r_q;

  assign p_d = (2*W)'(i_x) * (2*W)'(i_t);
  // Only the low W bits of the product matter for m.
  assign m_d = p_q[W-1:0] * QinvW;
  assign mq  = (2*W)'(m_q) * QW;
  assign r_d = W'((p2_q - mq) >>> W);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      p_q  <= '0;
      p2_q <= '0;
      m_q  <= '0;
      r_q  <= '0;
    end else if (i_en) begin
      p_q  <= p_d;
      p2_q <= p_q;
      m_q  <= m_d;
      r_q  <= r_d;
    end
  end

  assign o_r = r_q;

endmodule

// File: rtl/bfu_lanes.sv
// Multi-lane pipelined CT/GS butterfly with Montgomery reduction and global stall.
// Define BFU_LANES_CANON_EN to add a final stage mapping outputs into [0, Q).
module bfu_lanes
  import kyber_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned W     = 16,
  parameter int          Q     = KYBER_Q,
  parameter int          QINV  = KYBER_QINV,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  input  logic                 i_intt,
  input  logic [TAG_W-1:0]     i_tag,
  input  logic [LANES*W-1:0]   i_a,
  input  logic [LANES*W-1:0]   i_b,
  input  logic [LANES*W-1:0]   i_twiddle,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [LANES*W-1:0]   o_a,
  output logic [LANES*W-1:0]   o_b,
  output logic [TAG_W-1:0]     o_tag
);

  localparam logic signed [2*W-1:0] QW2 = (2*W)'(Q);

  logic             advance;
  logic [4:0]       valid_q;
  bfu_mode_e        mode_q [4];
  logic [TAG_W-1:0] tag_q  [5];

  // Every stage moves together; bubbles are kept.
  assign advance    = ~o_valid | i_out_ready;
  assign o_in_ready = advance;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) mode_q[i] <= BFU_CT;
      for (int i = 0; i < 5; i++) tag_q[i] <= '0;
    end else if (advance) begin
      valid_q   <= {valid_q[3:0], i_valid};
      mode_q[0] <= i_intt ? BFU_GS : BFU_CT;
      tag_q[0]  <= i_tag;
      for (int i = 1; i < 4; i++) mode_q[i] <= mode_q[i-1];
      for (int i = 1; i < 5; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef BFU_LANES_CANON_EN
  localparam logic signed [W-1:0] QS = W'(Q);

  function automatic logic signed [W-1:0] canon(input logic signed [W-1:0] x);
    if (x < 0) return x + QS;
    if (x >= QS) return x - QS;
    return x;
  endfunction

  logic             valid5_q;
  logic [TAG_W-1:0] tag5_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid5_q <= 1'b0;
      tag5_q   <= '0;
    end else if (advance) begin
      valid5_q <= valid_q[4];
      tag5_q   <= tag_q[4];
    end
  end

  assign o_valid = valid5_q;
  assign o_tag   = tag5_q;
`else
  assign o_valid = valid_q[4];
  assign o_tag   = tag_q[4];
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [W-1:0]   a_in, b_in, tw_in, x_d, x_q, tw_q, r;
    logic signed [W-1:0]   aux3_d, aux3_q, oa_d, ob_d, oa_q, ob_q;
    logic signed [2*W-1:0] s_in, aux_d;
    logic signed [2*W-1:0] aux_q [3];

    assign a_in  = i_a[l*W +: W];
    assign b_in  = i_b[l*W +: W];
    assign tw_in = i_twiddle[l*W +: W];
    assign s_in  = (2*W)'(a_in) + (2*W)'(b_in);

    // S0: GS pre-add/sub; aux carries a (CT) or a+b (GS) alongside the multiplier.
    always_comb begin
      x_d   = b_in;
      aux_d = (2*W)'(a_in);
      if (i_intt) begin
        x_d   = b_in - a_in;
        aux_d = s_in;
      end
    end

    always_comb begin
      aux3_d = W'(aux_q[2]);
      if (mode_q[2] == BFU_GS && aux_q[2] >= QW2) aux3_d = W'(aux_q[2] - QW2);
    end

    always_comb begin
      oa_d = aux3_q + r;
      ob_d = aux3_q - r;
      if (mode_q[3] == BFU_GS) begin
        oa_d = aux3_q;
        ob_d = r;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        x_q    <= '0;
        tw_q   <= '0;
        for (int i = 0; i < 3; i++) aux_q[i] <= '0;
        aux3_q <= '0;
        oa_q   <= '0;
        ob_q   <= '0;
      end else if (advance) begin
        x_q      <= x_d;
        tw_q     <= tw_in;
        aux_q[0] <= aux_d;
        aux_q[1] <= aux_q[0];
        aux_q[2] <= aux_q[1];
        aux3_q   <= aux3_d;
        oa_q     <= oa_d;
        ob_q     <= ob_d;
      end
    end

    bfu_mont_mul #(
      .W    (W),
      .Q    (Q),
      .QINV (QINV)
    ) u_mont (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (advance),
      .i_x     (x_q),
      .i_t     (tw_q),
      .o_r     (r)
    );

`ifdef BFU_LANES_CANON_EN
    logic signed [W-1:0] ca_q, cb_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        ca_q <= '0;
        cb_q <= '0;
      end else if (advance) begin
        ca_q <= canon(oa_q);
        cb_q <= canon(ob_q);
      end
    end

    assign o_a[l*W +: W] = ca_q;
    assign o_b[l*W +: W] = cb_q;
`else
    assign o_a[l*W +: W] = oa_q;
    assign o_b[l*W +: W] = ob_q;
`endif
  end

endmodule
